chi_home_node: RTL

- CHI home node that consumes single requests from the request node over a valid/response handshake.
- Owns a small word-addressed backing memory.
- Returns two response_valid pulses per transaction: an accept pulse, then, after a programmable latency, a completion pulse that carries read data.
- Sits directly downstream of the request node in the CHI subsystem.

---
 rtl/chi_home_node.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/chi_home_node.sv
// chi_home_node: CHI home node with a small word-addressed backing memory.
// Each accepted request produces an accept pulse, then MEM_LAT cycles later
// a completion pulse carrying read_data and resp_err.
// Optional build macro CHI_HN_STATS_EN adds saturating request/error counters
// (req_count, err_count).
// dbg_state exposes the FSM state for observation.
`timescale 1ns/1ps
module chi_home_node #(
    parameter int          MEM_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          MEM_LAT   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  command,
    input  logic [31:0] write_data,
    input  logic        request_valid,
    output logic [31:0] read_data,
    output logic        response_valid,
    output logic        resp_err,
    output logic [1:0]  dbg_state
`ifdef CHI_HN_STATS_EN
    ,
    output logic [15:0] req_count,
    output logic [15:0] err_count
`endif
);

    // Handshake: request_valid is a level held by the requester until it sees
    // the one-cycle accept pulse on response_valid; the second response_valid
    // pulse is the completion, with read_data/resp_err valid in that cycle and
    // held until the next completion.

    localparam int          IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_W  = 32'(MEM_DEPTH);
    localparam logic [15:0] LAT_INIT = 16'(MEM_LAT);
    localparam logic [3:0]  CMD_READ  = 4'b0001;
    localparam logic [3:0]  CMD_WRITE = 4'b0010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lat_cnt_q, lat_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] read_data_q, read_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_q [MEM_DEPTH];

    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             mem_we;
    logic             accept_evt;
    logic             err_evt;

`ifdef CHI_HN_STATS_EN
    logic [15:0] req_count_q, req_count_d;
    logic [15:0] err_count_q, err_count_d;
`endif

    // Decode the captured address into a word index and a range/alignment verdict.
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        in_range = (addr_q >= BASE_ADDR) && (offset[1:0] == 2'b00) &&
                   ({2'b00, offset[31:2]} < DEPTH_W);
        idx      = offset[IDX_W+1:2];
    end

    // Next-state logic: FSM transitions, capture, latency count and access.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        addr_d       = addr_q;
        cmd_d        = cmd_q;
        wdata_d      = wdata_q;
        read_data_d  = read_data_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = 1'b0;
        mem_we       = 1'b0;
        accept_evt   = 1'b0;
        err_evt      = 1'b0;
        case (state_q)
            IDLE: begin
                if (request_valid) begin
                    addr_d       = addr;
                    cmd_d        = command;
                    wdata_d      = write_data;
                    resp_valid_d = 1'b1;
                    lat_cnt_d    = LAT_INIT;
                    accept_evt   = 1'b1;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_cnt_q == 16'd1) begin
                    lat_cnt_d    = 16'd0;
                    resp_valid_d = 1'b1;
                    state_d      = RESPOND;
                    if (in_range && cmd_q == CMD_READ) begin
                        read_data_d = mem_q[idx];
                        resp_err_d  = 1'b0;
                    end else if (in_range && cmd_q == CMD_WRITE) begin
                        mem_we      = 1'b1;
                        read_data_d = 32'd0;
                        resp_err_d  = 1'b0;
                    end else begin
                        read_data_d = 32'd0;
                        resp_err_d  = 1'b1;
                        err_evt     = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 16'd1;
                end
            end
            RESPOND: begin
                // Wait for the requester to drop its request so a still-held
                // request is not captured a second time.
                if (!request_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CHI_HN_STATS_EN
    // Saturating statistics counters.
    always_comb begin
        req_count_d = req_count_q;
        err_count_d = err_count_q;
        if (accept_evt && req_count_q != 16'hFFFF) begin
            req_count_d = req_count_q + 16'd1;
        end
        if (err_evt && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
        end
    end
`endif

    // State, captured request, registered outputs and backing memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= 16'd0;
            addr_q       <= 32'd0;
            cmd_q        <= 4'd0;
            wdata_q      <= 32'd0;
            read_data_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
`ifdef CHI_HN_STATS_EN
            req_count_q  <= 16'd0;
            err_count_q  <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            addr_q       <= addr_d;
            cmd_q        <= cmd_d;
            wdata_q      <= wdata_d;
            read_data_q  <= read_data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            if (mem_we) begin
                mem_q[idx] <= wdata_q;
            end
`ifdef CHI_HN_STATS_EN
            req_count_q  <= req_count_d;
            err_count_q  <= err_count_d;
`endif
        end
    end

    assign read_data      = read_data_q;
    assign response_valid = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign dbg_state      = state_q;
`ifdef CHI_HN_STATS_EN
    assign req_count      = req_count_q;
    assign err_count      = err_count_q;
`endif

endmodule
